alarm_timer_param: RTL and testbench
====================================

Name: alarm_timer_param

Overview:
Parametrised countdown alarm, the successor to the fixed 4-digit alarm. The user sets MM:SS with minute and second buttons, and start runs, pauses or resumes the count. At 00:00 a tone-modulated buzzer sounds for a programmable time, then the block either returns to the preset (one-shot) or auto-restarts (repeat). It drives four BCD digits and four seven-segment patterns for the board display.

Parameters:
TICK_DIV, 100000000, clock cycles per countdown second (>=2)
MAX_MIN, 99, highest settable minute value (1..99); minute increment wraps past it to 0
RING_SECS, 10, seconds the buzzer sounds at expiry (>=1)
TONE_DIV, 50000, clock cycles per buzzer half-period (>=1)

Ports:
c  in  1  system clock
rst  in  1  synchronous reset, active-high
mb  in  1  minute button, level, already synchronised/debounced
sb  in  1  second button, level, already synchronised/debounced
start  in  1  start/pause/acknowledge button, level
rep  in  1  1 = auto-restart after ring, 0 = one-shot
l1  out  4  BCD minute tens
l2  out  4  BCD minute ones
l3  out  4  BCD second tens
l4  out  4  BCD second ones
L1..L4  out  7 each  seven-seg of l1..l4, active-low, bit6=a..bit0=g
buzz  out  1  buzzer drive
sec_tick  out  1  one-cycle pulse per elapsed second in RUN/RING
state_o  out  2  SET=0, RUN=1, PAUSE=2, RING=3

Behaviour:
- Reset (rst=1 at a c edge): state SET; time 00:00; preset 00:00; prescaler 0; buzz=0; sec_tick=0; edge registers cleared. L1..L4 show "0" (7'b0000001). Reset overrides everything, including mid-RUN and mid-RING.
- Buttons: rising-edge detected against a registered copy. An action takes effect on the edge after the cycle in which the 0->1 level is sampled, so latency is 1 cycle. A held button counts once.
- Time is held as BCD. Seconds range 00..59; minutes range 00..MAX_MIN.
- SET state:
  - mb edge: minutes+1, wrapping MAX_MIN->00.
  - sb edge: seconds+1, wrapping 59->00, no carry into minutes.
  - mb and sb in the same cycle: both apply.
  - start edge with time != 00:00: preset := time, prescaler := 0, go to RUN.
  - start edge with time = 00:00: ignored.
  - start has priority: mb/sb edges in the same cycle are discarded.
- RUN state:
  - The prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and asserts sec_tick for that cycle.
  - On a tick: if sec>0, sec-1; else min-1 and sec:=59.
  - The tick that produces 00:00 also moves to RING, in the same edge.
  - start edge -> PAUSE. A start edge coincident with the final tick: the tick wins and the state enters RING.
  - mb/sb are ignored in RUN, PAUSE and RING.
- PAUSE state: time and prescaler are frozen; sec_tick=0; start edge -> RUN, resuming from the held prescaler value.
- RING state:
  - The prescaler continues and sec_tick still pulses; a ring counter counts ticks.
  - buzz toggles every TONE_DIV cycles, starting at 1 on entry to RING. buzz=0 in all other states.
  - After RING_SECS ticks: time := preset; go to RUN (prescaler 0) if rep=1, else go to SET. rep is sampled at that moment.
  - start edge in RING: immediate acknowledge; time := preset, state SET, buzz=0 on the next cycle.
- Outputs are registered or decoded from registered state. The seven-seg decode is combinational from l1..l4. BCD values 10..15 cannot occur; decode them to blank (7'b1111111).

Test Plan (TICK_DIV=4, TONE_DIV=2, RING_SECS=2, MAX_MIN=3):
1. Reset, 3 mb pulses and 2 sb pulses -> l1..l4=0,3,0,2; a 4th mb pulse -> minutes 00; 60 sb pulses -> seconds return to 00; start at 00:00 -> state_o stays 0.
2. Set 00:03, start -> state_o=1; sec_tick pulses every 4 cycles; display reads 00:02, 00:01, 00:00. On the 00:00 tick state_o=3 and buzz toggles every 2 cycles.
3. Continue case 2 with rep=0 -> after 2 more ticks state_o=0, display 00:03, buzz=0; repeat with rep=1 -> state_o=1 and the countdown restarts from 00:03.
4. Set 01:00, start, after 1 tick -> 00:59; start -> PAUSE; hold 20 cycles -> display and sec_tick frozen; start -> resume; the next tick arrives after the remaining prescaler cycles, not a full 4.
5. In RING, pulse start -> state_o=0, display = preset, buzz=0 within 2 cycles of the press; held start produces no further action.
6. Assert rst mid-RUN at 00:02 and mid-RING -> next cycle state_o=0, l1..l4 all 0, buzz=0, sec_tick=0.

Source files
------------

// File: rtl/alarm_timer_param_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timer_param_if
// Description : User-facing signal bundle of the parametrised countdown alarm.
//               Buttons and mode select in; BCD digits, seven-segment
//               patterns, buzzer, second tick and state out.
//               master : drives buttons/mode, observes display (board/bench)
//               slave  : the alarm core
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_timer_param_if;
  logic       mb;        // minute button (level)
  logic       sb;        // second button (level)
  logic       start;     // start/pause/acknowledge button (level)
  logic       rep;       // 1 = auto-restart after ring
  logic [3:0] l1;        // BCD minute tens
  logic [3:0] l2;        // BCD minute ones
  logic [3:0] l3;        // BCD second tens
  logic [3:0] l4;        // BCD second ones
  logic [6:0] L1;        // seven-seg of l1, active-low, bit6=a..bit0=g
  logic [6:0] L2;
  logic [6:0] L3;
  logic [6:0] L4;
  logic       buzz;      // buzzer drive
  logic       sec_tick;  // one-cycle pulse per elapsed second
  logic [1:0] state_o;   // SET=0, RUN=1, PAUSE=2, RING=3

  modport master (
    output mb, sb, start, rep,
    input  l1, l2, l3, l4, L1, L2, L3, L4, buzz, sec_tick, state_o
  );

  modport slave (
    input  mb, sb, start, rep,
    output l1, l2, l3, l4, L1, L2, L3, L4, buzz, sec_tick, state_o
  );
endinterface
`default_nettype wire

// File: rtl/alarm_timer_param.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timer_param
// Description : Parametrised MM:SS countdown alarm with set/run/pause/ring
//               states, tone-modulated buzzer and one-shot or repeat mode.
// Ports       : c    - system clock
//               rst  - synchronous reset, active-high
//               bus  - alarm_timer_param_if.slave (buttons, mode, display,
//                      buzzer, sec_tick, state_o)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_timer_param #(
  parameter int TICK_DIV  = 100000000,
  parameter int MAX_MIN   = 99,
  parameter int RING_SECS = 10,
  parameter int TONE_DIV  = 50000
) (
  input  wire logic           c,
  input  wire logic           rst,
  alarm_timer_param_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;      // {min tens, min ones, sec tens, sec ones}
  logic [15:0]   preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tone_q, tone_d;
  logic [RW-1:0] ring_q, ring_d;
  logic          buzz_q, buzz_d;
  logic          sec_tick_q, sec_tick_d;
  logic [2:0]    btn_s_q, btn_s_d;    // {start, sb, mb} sampled
  logic [2:0]    btn_p_q, btn_p_d;    // previous sample, for edge detection

  logic [2:0]    btn_edge;
  logic          tick;
  logic [15:0]   time_dec;

  // Minute increment wraps past MAX_MIN (compared in BCD).
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == MAX_MIN_BCD)   return 8'h00;
    else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  // Second increment wraps 59 -> 00 with no carry.
  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    if (s[3:0] != 4'd9)      return {s[7:4], s[3:0] + 4'd1};
    else if (s[7:4] == 4'd5) return 8'h00;
    else                     return {s[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = t;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else if (s10 != 4'd0) begin
      s10 = s10 - 4'd1;
      s1  = 4'd9;
    end else begin
      s10 = 4'd5;
      s1  = 4'd9;
      if (m1 != 4'd0) begin
        m1 = m1 - 4'd1;
      end else begin
        m10 = m10 - 4'd1;
        m1  = 4'd9;
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign btn_edge = btn_s_q & ~btn_p_q;
  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign time_dec = dec_time(time_q);

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    preset_d   = preset_q;
    presc_d    = presc_q;
    tone_d     = tone_q;
    ring_d     = ring_q;
    buzz_d     = 1'b0;
    sec_tick_d = 1'b0;
    btn_s_d    = {bus.start, bus.sb, bus.mb};
    btn_p_d    = btn_s_q;

    case (state_q)
      ST_SET: begin
        // A start edge swallows any same-cycle mb/sb edge, even when ignored.
        if (btn_edge[2]) begin
          if (time_q != 16'h0000) begin
            preset_d = time_q;
            presc_d  = '0;
            state_d  = ST_RUN;
          end
        end else begin
          if (btn_edge[0]) time_d[15:8] = inc_min(time_q[15:8]);
          if (btn_edge[1]) time_d[7:0]  = inc_sec(time_q[7:0]);
        end
      end

      ST_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          sec_tick_d = 1'b1;
          time_d     = time_dec;
        end
        // Reaching 00:00 outranks a coincident pause request.
        if (tick && time_dec == 16'h0000) begin
          state_d = ST_RING;
          buzz_d  = 1'b1;
          tone_d  = '0;
          ring_d  = '0;
        end else if (btn_edge[2]) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        // Prescaler is held; resuming continues from the frozen count.
        if (btn_edge[2]) state_d = ST_RUN;
      end

      ST_RING: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tone_q == TW'(TONE_DIV - 1)) begin
          tone_d = '0;
          buzz_d = ~buzz_q;
        end else begin
          tone_d = tone_q + TW'(1);
          buzz_d = buzz_q;
        end
        if (tick) sec_tick_d = 1'b1;

        if (btn_edge[2]) begin
          time_d  = preset_q;
          presc_d = '0;
          buzz_d  = 1'b0;
          state_d = ST_SET;
        end else if (tick) begin
          if (ring_q == RW'(RING_SECS - 1)) begin
            time_d  = preset_q;
            presc_d = '0;
            buzz_d  = 1'b0;
            state_d = bus.rep ? ST_RUN : ST_SET;
          end else begin
            ring_d = ring_q + RW'(1);
          end
        end
      end

      default: state_d = ST_SET;
    endcase
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q    <= ST_SET;
      time_q     <= '0;
      preset_q   <= '0;
      presc_q    <= '0;
      tone_q     <= '0;
      ring_q     <= '0;
      buzz_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      btn_s_q    <= '0;
      btn_p_q    <= '0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      preset_q   <= preset_d;
      presc_q    <= presc_d;
      tone_q     <= tone_d;
      ring_q     <= ring_d;
      buzz_q     <= buzz_d;
      sec_tick_q <= sec_tick_d;
      btn_s_q    <= btn_s_d;
      btn_p_q    <= btn_p_d;
    end
  end

  assign bus.l1       = time_q[15:12];
  assign bus.l2       = time_q[11:8];
  assign bus.l3       = time_q[7:4];
  assign bus.l4       = time_q[3:0];
  assign bus.L1       = seg7(time_q[15:12]);
  assign bus.L2       = seg7(time_q[11:8]);
  assign bus.L3       = seg7(time_q[7:4]);
  assign bus.L4       = seg7(time_q[3:0]);
  assign bus.buzz     = buzz_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_timer_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_timer_param
// Description : Directed self-checking bench for alarm_timer_param with
//               TICK_DIV=4, TONE_DIV=2, RING_SECS=2, MAX_MIN=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_timer_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc;
  int   nticks;

  always #5 clk = ~clk;

  alarm_timer_param_if bus_if ();

  alarm_timer_param #(
    .TICK_DIV (4),
    .MAX_MIN  (3),
    .RING_SECS(2),
    .TONE_DIV (2)
  ) dut (
    .c  (clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = mb, 1 = sb, 2 = start
  task automatic press(input int which);
    if (which == 0) bus_if.mb = 1'b1;
    else if (which == 1) bus_if.sb = 1'b1;
    else bus_if.start = 1'b1;
    step(3);
    bus_if.mb = 1'b0; bus_if.sb = 1'b0; bus_if.start = 1'b0;
    step(2);
  endtask

  // Cycles until the next sec_tick sample; -1 if none within the bound.
  task automatic wait_tick(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step(1);
      cycles++;
      if (bus_if.sec_tick) found = 1'b1;
    end
    if (!found) cycles = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] disp();
    return {bus_if.l1, bus_if.l2, bus_if.l3, bus_if.l4};
  endfunction

  initial begin
    bus_if.mb = 1'b0; bus_if.sb = 1'b0; bus_if.start = 1'b0; bus_if.rep = 1'b0;
    step(2);
    // ---- reset state ----
    check("rst_state", bus_if.state_o, 2'd0);
    check("rst_time", disp(), 16'h0000);
    check("rst_buzz", bus_if.buzz, 1'b0);
    check("rst_tick", bus_if.sec_tick, 1'b0);
    check("rst_seg", {bus_if.L1, bus_if.L2, bus_if.L3, bus_if.L4},
          {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});
    rst = 1'b0;

    // ---- case 1: setting ----
    repeat (3) press(0);
    repeat (2) press(1);
    check("set_0302", disp(), 16'h0302);
    check("seg_0302", {bus_if.L1, bus_if.L2, bus_if.L3, bus_if.L4},
          {7'b0000001, 7'b0000110, 7'b0000001, 7'b0010010});
    press(0);
    check("min_wrap", disp(), 16'h0002);
    do_reset();
    repeat (59) press(1);
    check("sec_59", disp(), 16'h0059);
    press(1);
    check("sec_wrap", disp(), 16'h0000);
    press(2);
    step(3);
    check("start_zero", bus_if.state_o, 2'd0);

    // ---- case 2: countdown to ring ----
    repeat (3) press(1);
    press(2);
    check("run_state", bus_if.state_o, 2'd1);
    wait_tick(cyc);
    check("run_0002", disp(), 16'h0002);
    wait_tick(cyc);
    check("tick_period1", cyc, 4);
    check("run_0001", disp(), 16'h0001);
    wait_tick(cyc);
    check("tick_period2", cyc, 4);
    check("run_0000", disp(), 16'h0000);
    check("ring_state", bus_if.state_o, 2'd3);
    check("buzz_e0", bus_if.buzz, 1'b1);
    step(1); check("buzz_e1", bus_if.buzz, 1'b1);
    step(1); check("buzz_e2", bus_if.buzz, 1'b0);
    step(1); check("buzz_e3", bus_if.buzz, 1'b0);
    step(1); check("buzz_e4", bus_if.buzz, 1'b1);

    // ---- case 3: one-shot, then repeat ----
    wait_tick(cyc);
    check("ring_tick", cyc, 4);
    check("oneshot_state", bus_if.state_o, 2'd0);
    check("oneshot_time", disp(), 16'h0003);
    check("oneshot_buzz", bus_if.buzz, 1'b0);
    bus_if.rep = 1'b1;
    press(2);
    repeat (3) wait_tick(cyc);
    check("rep_ring", bus_if.state_o, 2'd3);
    repeat (2) wait_tick(cyc);
    check("rep_state", bus_if.state_o, 2'd1);
    check("rep_time", disp(), 16'h0003);
    wait_tick(cyc);
    check("rep_period", cyc, 4);
    check("rep_0002", disp(), 16'h0002);

    // ---- case 6a: reset mid-RUN at 00:02 ----
    rst = 1'b1;
    step(1);
    check("rstrun_state", bus_if.state_o, 2'd0);
    check("rstrun_time", disp(), 16'h0000);
    check("rstrun_buzz", bus_if.buzz, 1'b0);
    check("rstrun_tick", bus_if.sec_tick, 1'b0);
    rst = 1'b0;
    bus_if.rep = 1'b0;
    step(1);

    // ---- case 4: pause and resume ----
    press(0);
    press(2);
    wait_tick(cyc);
    check("run_0059", disp(), 16'h0059);
    bus_if.start = 1'b1;          // pause lands with the prescaler at 2
    step(2);
    bus_if.start = 1'b0;
    check("pause_state", bus_if.state_o, 2'd2);
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus_if.sec_tick) nticks++;
    end
    check("pause_ticks", nticks, 0);
    check("pause_time", disp(), 16'h0059);
    check("pause_hold", bus_if.state_o, 2'd2);
    bus_if.start = 1'b1;
    wait_tick(cyc);
    check("resume_lat", cyc, 4);
    check("resume_0058", disp(), 16'h0058);
    bus_if.start = 1'b0;
    step(2);

    // ---- case 5: acknowledge in RING ----
    do_reset();
    press(1);
    press(2);
    wait_tick(cyc);
    check("ack_ring", bus_if.state_o, 2'd3);
    bus_if.start = 1'b1;
    step(2);
    check("ack_state", bus_if.state_o, 2'd0);
    check("ack_time", disp(), 16'h0001);
    check("ack_buzz", bus_if.buzz, 1'b0);
    step(10);
    check("ack_held", bus_if.state_o, 2'd0);
    bus_if.start = 1'b0;
    step(2);

    // ---- case 6b: reset mid-RING ----
    press(2);
    wait_tick(cyc);
    check("rring_pre", bus_if.state_o, 2'd3);
    rst = 1'b1;
    step(1);
    check("rstring_state", bus_if.state_o, 2'd0);
    check("rstring_time", disp(), 16'h0000);
    check("rstring_buzz", bus_if.buzz, 1'b0);
    check("rstring_tick", bus_if.sec_tick, 1'b0);
    rst = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
